wb_sram_bridge: RTL and testbench

Wishbone classic responder that gives the Caravel management core direct word access to the OpenRAM macros. It sits in `user_project_wrapper` on the `wbs_*` port, which is otherwise tied off. It drives the shared SRAM port-0 bus (`addr0`/`din0`/`web0`/`wmask0`) plus one `csb0` per chip, and returns registered read data. It is the bus-side counterpart to `openram_testchip`: the core drives the macros through Wishbone instead of the GPIO/LA scan chain. An external mux in the wrapper selects between the two drivers.

---
 rtl/wb_sram_bridge_pkg.sv | 21 ++
 rtl/wb_sram_dout_mux.sv | 26 ++
 rtl/wb_sram_bridge.sv | 158 +++++++++++++++
 tb/tb_wb_sram_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram_bridge_pkg.sv
// Shared sizing constants and FSM encoding for the Wishbone-to-SRAM bridge.
// No logic; constants only.
// Imported by the bridge top and its read-data mux.
package wb_sram_bridge_pkg;

  localparam int DEF_DATA_SIZE  = 32;
  localparam int DEF_ADDR_SIZE  = 11;
  localparam int DEF_WMASK_SIZE = DEF_DATA_SIZE / 8;
  localparam int DEF_MAX_CHIPS  = 16;

  // Chip index comes from adr[23:20], so it is always 4 bits wide.
  localparam int CHIP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/wb_sram_dout_mux.sv
// Selects one chip's dout0 slice out of the flattened SRAM read buses.
// Purely combinational, zero latency.
// No handshake; returns 0 for an out-of-range or unpopulated chip index.
module wb_sram_dout_mux
  import wb_sram_bridge_pkg::*;
#(
  parameter int                   DATA_SIZE = DEF_DATA_SIZE,
  parameter int                   MAX_CHIPS = DEF_MAX_CHIPS,
  parameter logic [MAX_CHIPS-1:0] CHIP_MASK = 16'h1F1F
) (
  input  logic [CHIP_W-1:0]              chip_i,
  input  logic [MAX_CHIPS*DATA_SIZE-1:0] dout_i,
  output logic [DATA_SIZE-1:0]           dat_o
);

  // Only a populated chip whose index matches can drive the result.
  always_comb begin
    dat_o = '0;
    for (int i = 0; i < MAX_CHIPS; i++) begin
      if (CHIP_MASK[i] && (int'(chip_i) == i)) begin
        dat_o = dout_i[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone classic responder giving word access to the OpenRAM port-0 bus.
// Latency: write ack 2 cycles after sampling, read ack 3, unpopulated chip 1.
// Single outstanding request; cyc drop before ack aborts without an ack.
module wb_sram_bridge
  import wb_sram_bridge_pkg::*;
#(
  parameter int                   DATA_SIZE  = DEF_DATA_SIZE,
  parameter int                   ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int                   WMASK_SIZE = DEF_WMASK_SIZE,
  parameter int                   MAX_CHIPS  = DEF_MAX_CHIPS,
  parameter logic [31:0]          BASE_ADDR  = 32'h3000_0000,
  parameter logic [MAX_CHIPS-1:0] CHIP_MASK  = 16'h1F1F
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_we_i,
  input  logic [WMASK_SIZE-1:0]          wbs_sel_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [DATA_SIZE-1:0]           wbs_dat_i,
  output logic                           wbs_ack_o,
  output logic [DATA_SIZE-1:0]           wbs_dat_o,
  output logic [ADDR_SIZE-1:0]           addr0,
  output logic [DATA_SIZE-1:0]           din0,
  output logic                           web0,
  output logic [WMASK_SIZE-1:0]          wmask0,
  output logic [MAX_CHIPS-1:0]           csb0,
  input  logic [MAX_CHIPS*DATA_SIZE-1:0] sram_dout0
);

  bridge_state_e state_q, state_d;

  logic [CHIP_W-1:0]     chip_q, chip_d;
  logic                  we_q, we_d;
  logic [DATA_SIZE-1:0]  rdbuf_q, rdbuf_d;
  logic [ADDR_SIZE-1:0]  addr0_q, addr0_d;
  logic [DATA_SIZE-1:0]  din0_q, din0_d;
  logic                  web0_q, web0_d;
  logic [WMASK_SIZE-1:0] wmask0_q, wmask0_d;
  logic [MAX_CHIPS-1:0]  csb0_q, csb0_d;

  logic                  req;
  logic [CHIP_W-1:0]     req_chip;
  logic [ADDR_SIZE-1:0]  req_word;
  logic                  req_pop;
  logic [DATA_SIZE-1:0]  mux_dat;

  // Chip-group bits between the word field and the chip field, and the byte
  // offset, carry no meaning here: words wrap inside each chip.
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[19:ADDR_SIZE+2], wbs_adr_i[1:0]};

  function automatic logic chip_populated(input logic [CHIP_W-1:0] c);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_CHIPS; i++) begin
      if (CHIP_MASK[i] && (int'(c) == i)) p = 1'b1;
    end
    return p;
  endfunction

  assign req      = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
  assign req_chip = wbs_adr_i[23:20];
  assign req_word = wbs_adr_i[ADDR_SIZE+1:2];
  assign req_pop  = chip_populated(req_chip);

  wb_sram_dout_mux #(
    .DATA_SIZE (DATA_SIZE),
    .MAX_CHIPS (MAX_CHIPS),
    .CHIP_MASK (CHIP_MASK)
  ) u_dout_mux (
    .chip_i (chip_q),
    .dout_i (sram_dout0),
    .dat_o  (mux_dat)
  );

  // State register and datapath registers, synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      chip_q   <= '0;
      we_q     <= 1'b0;
      rdbuf_q  <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      csb0_q   <= '1;
    end else begin
      state_q  <= state_d;
      chip_q   <= chip_d;
      we_q     <= we_d;
      rdbuf_q  <= rdbuf_d;
      addr0_q  <= addr0_d;
      din0_q   <= din0_d;
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      csb0_q   <= csb0_d;
    end
  end

  // Next-state: ACK always returns to IDLE, guaranteeing an idle gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req) state_d = req_pop ? ST_ISSUE : ST_ACK;
      ST_ISSUE: if (!wbs_cyc_i) state_d = ST_IDLE;
                else state_d = we_q ? ST_ACK : ST_WAIT;
      ST_WAIT:  state_d = wbs_cyc_i ? ST_ACK : ST_IDLE;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered SRAM pins and request latches; the SRAM
  // pins are loaded on entry to ISSUE so they are stable during that cycle.
  always_comb begin
    chip_d   = chip_q;
    we_d     = we_q;
    rdbuf_d  = rdbuf_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    wmask0_d = wmask0_q;
    web0_d   = 1'b1;
    csb0_d   = '1;
    if (state_q == ST_IDLE && req) begin
      chip_d = req_chip;
      we_d   = wbs_we_i;
      if (req_pop) begin
        addr0_d  = req_word;
        din0_d   = wbs_dat_i;
        wmask0_d = wbs_sel_i;
        web0_d   = ~wbs_we_i;
        for (int i = 0; i < MAX_CHIPS; i++) begin
          if (int'(req_chip) == i) csb0_d[i] = 1'b0;
        end
      end else begin
        rdbuf_d = '0;
      end
    end else if (state_q == ST_WAIT && wbs_cyc_i) begin
      rdbuf_d = mux_dat;
    end
  end

  // Wishbone response: one-cycle ack, read data only on reads.
  always_comb begin
    wbs_ack_o = (state_q == ST_ACK);
    wbs_dat_o = (wbs_ack_o && !we_q) ? rdbuf_q : '0;
  end

  assign addr0  = addr0_q;
  assign din0   = din0_q;
  assign web0   = web0_q;
  assign wmask0 = wmask0_q;
  assign csb0   = csb0_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge with a behavioural SRAM model.
// Expected acks (data + cycle) are queued at issue and checked by a monitor.
module tb_wb_sram_bridge;

  logic         clk;
  logic         rst;
  logic         stb, wb_cyc, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat;
  logic         ack;
  logic [31:0]  rdat;
  logic [10:0]  addr0;
  logic [31:0]  din0;
  logic         web0;
  logic [3:0]   wmask0;
  logic [15:0]  csb0;
  logic [511:0] sram_dout0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  bit csb_seen = 0;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  wb_sram_bridge dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (wb_cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .addr0      (addr0),
    .din0       (din0),
    .web0       (web0),
    .wmask0     (wmask0),
    .csb0       (csb0),
    .sram_dout0 (sram_dout0)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // SRAM model: synchronous, dout updates after the clock edge of a read.
  logic [31:0] mem [16][2048];
  logic [31:0] dout_m [16];

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (rst) begin
        dout_m[i] <= 32'hD0D0_0000 + i;
      end else if (!csb0[i]) begin
        if (!web0) begin
          for (int b = 0; b < 4; b++)
            if (wmask0[b]) mem[i][addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end else begin
          dout_m[i] <= mem[i][addr0];
        end
      end
    end
  end

  always_comb begin
    sram_dout0 = '0;
    for (int i = 0; i < 16; i++) sram_dout0[i*32 +: 32] = dout_m[i];
  end

  always @(negedge clk) if (csb0 !== 16'hFFFF) csb_seen = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: every ack must match the oldest expectation in data and cycle.
  always @(negedge clk) begin
    if (ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got ack with data %h, expected no ack (cycle %0d)", rdat, cyc_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_dat", {32'h0, rdat}, {32'h0, e.dat});
        chk("ack_cycle", 64'(cyc_cnt), 64'(e.cyc));
      end
    end
  end

  task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit push, input logic [31:0] exp_dat,
                           input int lat);
    @(posedge clk); #1;
    stb = 1; wb_cyc = 1; we = w; adr = a; dat = d; sel = s;
    if (push) exp_q.push_back('{exp_dat, cyc_cnt + lat});
  endtask

  task automatic finish_req(input string name);
    int k;
    k = 0;
    while (!ack && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_ack_seen"}, {63'h0, ack}, 64'h1);
    @(posedge clk); #1;
    stb = 0; wb_cyc = 0; we = 0;
  endtask

  // Check the SRAM pins during the ISSUE cycle (cycle 1 of the request).
  task automatic chk_issue(input string name, input logic [15:0] e_csb, input logic e_web,
                           input logic [10:0] e_addr, input logic [3:0] e_mask,
                           input logic [31:0] e_din);
    @(negedge clk);
    @(negedge clk);
    chk({name, "_csb0"}, 64'(csb0), 64'(e_csb));
    chk({name, "_web0"}, 64'(web0), 64'(e_web));
    chk({name, "_addr0"}, 64'(addr0), 64'(e_addr));
    chk({name, "_wmask0"}, 64'(wmask0), 64'(e_mask));
    if (!e_web) chk({name, "_din0"}, 64'(din0), 64'(e_din));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_csb0"}, 64'(csb0), 64'hFFFF);
    chk({name, "_web0"}, 64'(web0), 64'h1);
    chk({name, "_ack"}, 64'(ack), 64'h0);
    chk({name, "_dat"}, 64'(rdat), 64'h0);
    chk({name, "_addr0"}, 64'(addr0), 64'h0);
    chk({name, "_din0"}, 64'(din0), 64'h0);
    chk({name, "_wmask0"}, 64'(wmask0), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; stb = 0; wb_cyc = 0; we = 0; sel = 0; adr = 0; dat = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 0;

    // Full write, chip 1, word 4.
    start_req(1, 32'h3010_0010, 32'hA5A5_1234, 4'hF, 1, 32'h0, 2);
    chk_issue("wr1", 16'hFFFD, 1'b0, 11'd4, 4'hF, 32'hA5A5_1234);
    finish_req("wr1");

    start_req(0, 32'h3010_0010, 32'h0, 4'hF, 1, 32'hA5A5_1234, 3);
    chk_issue("rd1", 16'hFFFD, 1'b1, 11'd4, 4'hF, 32'h0);
    finish_req("rd1");

    // Byte lane 2 write.
    start_req(1, 32'h3010_0010, 32'h00CC_0000, 4'b0100, 1, 32'h0, 2);
    chk_issue("bwr", 16'hFFFD, 1'b0, 11'd4, 4'b0100, 32'h00CC_0000);
    finish_req("bwr");
    start_req(0, 32'h3010_0010, 32'h0, 4'hF, 1, 32'hA5CC_1234, 3);
    finish_req("brd");

    // sel=0 write is still acked but changes nothing.
    start_req(1, 32'h3010_0010, 32'hFFFF_FFFF, 4'h0, 1, 32'h0, 2);
    chk_issue("sel0", 16'hFFFD, 1'b0, 11'd4, 4'h0, 32'hFFFF_FFFF);
    finish_req("sel0");

    // Read aborted in WAIT; the next request must start immediately.
    start_req(0, 32'h3010_0010, 32'h0, 4'hF, 0, 32'h0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb = 0; wb_cyc = 0;
    @(negedge clk);
    chk("abort_no_ack", 64'(ack), 64'h0);
    start_req(0, 32'h3010_0010, 32'h0, 4'hF, 1, 32'hA5CC_1234, 3);
    finish_req("post_abort");

    // Unpopulated chip 5.
    @(posedge clk); #1;
    csb_seen = 0;
    start_req(0, 32'h3050_0000, 32'h0, 4'hF, 1, 32'h0, 1);
    finish_req("unpop");
    chk("unpop_csb_quiet", 64'(csb_seen), 64'h0);

    // Word bits above ADDR_SIZE wrap: 0x2004 -> word 1 of chip 2.
    start_req(1, 32'h3020_2004, 32'h600D_F00D, 4'hF, 1, 32'h0, 2);
    chk_issue("wrap", 16'hFFFB, 1'b0, 11'd1, 4'hF, 32'h600D_F00D);
    finish_req("wrap_wr");
    start_req(0, 32'h3020_0004, 32'h0, 4'hF, 1, 32'h600D_F00D, 3);
    finish_req("wrap_rd");

    // Upper chip group.
    start_req(1, 32'h3080_0000, 32'h1357_9BDF, 4'hF, 1, 32'h0, 2);
    chk_issue("chip8", 16'hFEFF, 1'b0, 11'd0, 4'hF, 32'h1357_9BDF);
    finish_req("chip8_wr");
    start_req(0, 32'h3080_0000, 32'h0, 4'hF, 1, 32'h1357_9BDF, 3);
    finish_req("chip8_rd");

    // Base mismatch: held 10 cycles, no SRAM activity, no ack.
    @(posedge clk); #1;
    csb_seen = 0;
    start_req(0, 32'h2000_0000, 32'h0, 4'hF, 0, 32'h0, 0);
    begin
      bit ack_seen;
      ack_seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (ack) ack_seen = 1;
      end
      chk("mismatch_no_ack", 64'(ack_seen), 64'h0);
      chk("mismatch_csb_quiet", 64'(csb_seen), 64'h0);
    end
    @(posedge clk); #1;
    stb = 0; wb_cyc = 0;

    // Reset during ISSUE of a read: reset values next cycle, no ack.
    start_req(0, 32'h3010_0010, 32'h0, 4'hF, 0, 32'h0, 0);
    @(posedge clk); #1;
    rst = 1; stb = 0; wb_cyc = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 0;

    start_req(0, 32'h3010_0010, 32'h0, 4'hF, 1, 32'hA5CC_1234, 3);
    finish_req("post_rst");

    repeat (3) @(posedge clk);
    chk("pending_expectations", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
